// File: rtl/demux_pkg.sv
// Shared constants for the registered 1-to-2 byte demultiplexer.
package demux_pkg;

  localparam logic CH0      = 1'b0;
  localparam logic CH1      = 1'b1;
  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_ALT = 1'b1;

  localparam int BYTE_W = 8;
  localparam int CNT_W  = 8;

endpackage

// File: rtl/demux_reg_if.sv
// Bus bundle for demux_reg: one input byte stream, two output channels,
// per-channel counters and the round-robin pointer for debug visibility.
//
// Handshake rule (all three streams): a byte transfers on a rising edge
// where valid and ready are both 1. A producer holds valid and data until
// the transfer. in_ready is the only combinational output; it depends on
// mode, sel, the round-robin pointer and y0_ready/y1_ready, never on
// in_valid. y*_valid and y* come straight from registers.
interface demux_reg_if
  import demux_pkg::*;
#(
  parameter int WIDTH = BYTE_W,
  parameter int CW    = CNT_W
) ();

  logic             mode;
  logic             sel;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] y0;
  logic             y0_valid;
  logic             y0_ready;
  logic [WIDTH-1:0] y1;
  logic             y1_valid;
  logic             y1_ready;
  logic [CW-1:0]    cnt0;
  logic [CW-1:0]    cnt1;
  logic             rr;

  modport master (
    output mode, sel, in_data, in_valid, y0_ready, y1_ready,
    input  in_ready, y0, y0_valid, y1, y1_valid, cnt0, cnt1, rr
  );

  modport slave (
    input  mode, sel, in_data, in_valid, y0_ready, y1_ready,
    output in_ready, y0, y0_valid, y1, y1_valid, cnt0, cnt1, rr
  );

endinterface

// File: rtl/demux_slot.sv
// One output channel: data holding register, valid flag and a wrapping
// count of bytes loaded into it.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = BYTE_W,
  parameter int CW    = CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             ready,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] y,
  output logic             valid,
  output logic [CW-1:0]    cnt
);

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  // Load wins over drain so a full slot can be refilled in the cycle it is
  // emptied; a plain drain only clears valid and leaves y holding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y     <= '0;
      valid <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      y     <= data;
      valid <= 1'b1;
      cnt   <= cnt + ONE;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_reg.sv
// Registered 1-to-2 byte demultiplexer. Each accepted byte is steered to
// channel sel (explicit mode) or to alternating channels (round-robin mode).
module demux_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = BYTE_W,
  parameter int CW    = CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  demux_reg_if.slave  bus
);

  logic rr;
  logic tgt;
  logic tgt_free;
  logic accept;
  logic load0;
  logic load1;

  // Target channel and whether it can take a byte this cycle: it is free
  // when empty or when its consumer is taking the held byte now.
  always_comb begin
    tgt      = (bus.mode == MODE_ALT) ? rr : bus.sel;
    tgt_free = (tgt == CH0) ? (~bus.y0_valid | bus.y0_ready)
                            : (~bus.y1_valid | bus.y1_ready);
  end

  assign bus.in_ready = tgt_free;
  assign accept       = bus.in_valid & tgt_free;
  assign load0        = accept & (tgt == CH0);
  assign load1        = accept & (tgt == CH1);
  assign bus.rr       = rr;

  // Round-robin pointer advances only on an accepted byte in alternate mode,
  // so a stall or a spell in explicit mode resumes where it left off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr <= CH0;
    end else if (accept && (bus.mode == MODE_ALT)) begin
      rr <= ~rr;
    end
  end

  demux_slot #(.WIDTH(WIDTH), .CW(CW)) u_slot0 (
    .clk   (clk),
    .reset (reset),
    .load  (load0),
    .ready (bus.y0_ready),
    .data  (bus.in_data),
    .y     (bus.y0),
    .valid (bus.y0_valid),
    .cnt   (bus.cnt0)
  );

  demux_slot #(.WIDTH(WIDTH), .CW(CW)) u_slot1 (
    .clk   (clk),
    .reset (reset),
    .load  (load1),
    .ready (bus.y1_ready),
    .data  (bus.in_data),
    .y     (bus.y1),
    .valid (bus.y1_valid),
    .cnt   (bus.cnt1)
  );

endmodule

// File: tb/tb_demux_reg.sv
// Bench for demux_reg: directed scenarios followed by random traffic, all
// checked against a channel-level reference model.
module tb_demux_reg;

  logic clk;
  logic reset;

  demux_reg_if #(.WIDTH(8), .CW(8)) bus ();

  demux_reg #(.WIDTH(8), .CW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: each channel is a one-entry box with a byte and a count.
  bit m_full [2];
  int m_data [2];
  int m_cnt  [2];
  int m_rr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_full[k] = 1'b0;
      m_data[k] = 0;
      m_cnt[k]  = 0;
    end
    m_rr = 0;
  endtask

  task automatic check_outputs();
    chk("y0",       {24'h0, bus.y0},   m_data[0]);
    chk("y0_valid", {31'h0, bus.y0_valid}, {31'h0, m_full[0]});
    chk("y1",       {24'h0, bus.y1},   m_data[1]);
    chk("y1_valid", {31'h0, bus.y1_valid}, {31'h0, m_full[1]});
    chk("cnt0",     {24'h0, bus.cnt0}, m_cnt[0]);
    chk("cnt1",     {24'h0, bus.cnt1}, m_cnt[1]);
    chk("rr",       {31'h0, bus.rr},   m_rr);
  endtask

  task automatic idle_inputs();
    bus.mode     = 1'b0;
    bus.sel      = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    bus.y0_ready = 1'b0;
    bus.y1_ready = 1'b0;
  endtask

  // One clock of traffic: drive after an edge, check in_ready mid-cycle,
  // advance the model at the edge, check registered outputs just after it.
  task automatic step(input bit md, input bit sl, input int d, input bit v,
                      input bit r0, input bit r1);
    int t;
    bit exp_rdy;
    bit acc;
    bit rdy [2];
    bus.mode     = md;
    bus.sel      = sl;
    bus.in_data  = d[7:0];
    bus.in_valid = v;
    bus.y0_ready = r0;
    bus.y1_ready = r1;
    rdy[0] = r0;
    rdy[1] = r1;
    @(negedge clk);
    t = md ? m_rr : int'(sl);
    exp_rdy = !m_full[t] || rdy[t];
    chk("in_ready", {31'h0, bus.in_ready}, {31'h0, exp_rdy});
    acc = v && exp_rdy;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (acc && t == k) begin
        m_full[k] = 1'b1;
        m_data[k] = d & 8'hFF;
        m_cnt[k]  = (m_cnt[k] + 1) % 256;
      end else if (m_full[k] && rdy[k]) begin
        m_full[k] = 1'b0;
      end
    end
    if (acc && md) m_rr = 1 - m_rr;
    check_outputs();
  endtask

  // Asynchronous reset raised between edges; outputs must clear before any edge.
  task automatic async_reset();
    idle_inputs();
    reset = 1'b1;
    #2;
    model_reset();
    chk("rst_y0",       {24'h0, bus.y0}, 32'h0);
    chk("rst_y0_valid", {31'h0, bus.y0_valid}, 32'h0);
    chk("rst_cnt0",     {24'h0, bus.cnt0}, 32'h0);
    chk("rst_y1_valid", {31'h0, bus.y1_valid}, 32'h0);
    chk("rst_cnt1",     {24'h0, bus.cnt1}, 32'h0);
    chk("rst_rr",       {31'h0, bus.rr}, 32'h0);
    chk("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  int c0;
  int c1;

  initial begin
    idle_inputs();
    reset = 1'b1;
    model_reset();
    #1;
    check_outputs();
    chk("init_in_ready", {31'h0, bus.in_ready}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Reset mid-operation.
    step(0, 0, 8'hA5, 1, 0, 0);
    chk("load_a5", {24'h0, bus.y0}, 32'hA5);
    async_reset();

    // Explicit routing with both consumers stalled.
    step(0, 0, 8'h11, 1, 0, 0);
    step(0, 1, 8'h22, 1, 0, 0);
    chk("expl_y0", {24'h0, bus.y0}, 32'h11);
    chk("expl_y1", {24'h0, bus.y1}, 32'h22);
    chk("expl_cnt0", {24'h0, bus.cnt0}, 32'h1);
    chk("expl_cnt1", {24'h0, bus.cnt1}, 32'h1);
    step(0, 0, 8'h99, 1, 0, 0);
    chk("blocked_y0", {24'h0, bus.y0}, 32'h11);
    chk("blocked_cnt0", {24'h0, bus.cnt0}, 32'h1);

    // Drain both, then alternate a back-to-back stream.
    step(0, 0, 8'h00, 0, 1, 1);
    for (int i = 1; i <= 6; i++) begin
      step(1, 0, i, 1, 1, 1);
      if (i % 2 == 1) chk("alt_ch0", {24'h0, bus.y0}, i);
      else            chk("alt_ch1", {24'h0, bus.y1}, i);
    end
    chk("alt_cnt0", {24'h0, bus.cnt0}, 32'h4);
    chk("alt_cnt1", {24'h0, bus.cnt1}, 32'h4);

    // Backpressure on ch1 holds the round-robin pointer.
    step(1, 0, 8'h07, 1, 1, 0);
    step(1, 0, 8'h08, 1, 1, 0);
    chk("bp_rr_hold", {31'h0, bus.rr}, 32'h1);
    chk("bp_y1_hold", {24'h0, bus.y1}, 32'h06);
    step(1, 0, 8'h08, 1, 1, 1);
    chk("bp_y1_land", {24'h0, bus.y1}, 32'h08);
    chk("bp_rr_adv", {31'h0, bus.rr}, 32'h0);

    // Simultaneous drain and load on ch0.
    step(0, 0, 8'h33, 1, 0, 0);
    c0 = m_cnt[0];
    step(0, 0, 8'h44, 1, 1, 0);
    chk("dl_y0", {24'h0, bus.y0}, 32'h44);
    chk("dl_valid", {31'h0, bus.y0_valid}, 32'h1);
    chk("dl_cnt0", {24'h0, bus.cnt0}, (c0 + 1) % 256);

    // Counter wrap on ch0 with ch1 untouched.
    async_reset();
    step(0, 1, 8'h5A, 1, 0, 1);
    c1 = m_cnt[1];
    for (int i = 0; i < 256; i++) step(0, 0, $urandom_range(0, 255), 1, 1, 0);
    chk("wrap_cnt0", {24'h0, bus.cnt0}, 32'h0);
    chk("wrap_cnt1", {24'h0, bus.cnt1}, c1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 255),
           $urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/demux_reg.md
Name: demux_reg

Overview:
- Registered 1-to-2 byte demultiplexer: the receive-side counterpart of the team's 2:1 byte mux.
- Accepts one byte stream through a valid/ready handshake and steers each byte into one of two output holding registers.
- Each output has its own valid/ready handshake.
- Routing is either explicit (sel input) or automatic alternation (round-robin), so a mux-merged stream can be split back out.
- Per-channel byte counters support debug display on the seven-segment path.

Parameters:
- WIDTH, 8, data width of input and both outputs.
- CNT_W, 8, width of each per-channel accepted-byte counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- mode  input  1  0 = explicit routing by sel, 1 = alternate channels starting at ch0.
- sel  input  1  target channel when mode=0; sampled only on an accepted byte.
- in_data  input  WIDTH  input byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  demux can accept this cycle.
- y0  output  WIDTH  channel-0 held byte.
- y0_valid  output  1  y0 is holding an unconsumed byte.
- y0_ready  input  1  channel-0 consumer takes y0 this cycle.
- y1  output  WIDTH  channel-1 held byte.
- y1_valid  output  1  y1 is holding an unconsumed byte.
- y1_ready  input  1  channel-1 consumer takes y1 this cycle.
- cnt0  output  CNT_W  bytes accepted into channel 0.
- cnt1  output  CNT_W  bytes accepted into channel 1.

Behaviour:
- Reset, asynchronous: y0 = y1 = 0, y0_valid = y1_valid = 0, cnt0 = cnt1 = 0, round-robin pointer rr = 0. in_ready is therefore 1 immediately after reset. Any held bytes are discarded, including on reset mid-transfer.
- Target channel (combinational): t = mode ? rr : sel.
- in_ready = ~yt_valid | yt_ready. This is combinational from y*_ready, mode, sel and rr. It is the only comb path and no other output depends combinationally on inputs.
- Accept = in_valid & in_ready.
- On accept: yt <= in_data; yt_valid <= 1; cntt <= cntt + 1, wrapping modulo 2^CNT_W (255 -> 0 at default); if mode = 1, rr <= ~rr.
- Drain of channel k: yk_valid & yk_ready with no same-cycle accept into k -> yk_valid <= 0. yk holds its last value and is not cleared.
- Simultaneous drain and accept on the same channel: new byte loads, valid stays 1. This gives one byte per cycle throughput.
- Drain on one channel while accepting into the other: both take effect independently.
- Latency: a byte accepted at edge N is visible on yt with valid=1 after edge N.
- Blocking: if target channel is full and not draining, in_ready = 0. No byte is dropped or overwritten, and rr does not advance.
- mode = 0 leaves rr unchanged. Switching to mode = 1 resumes alternation from the retained rr.
- sel and mode may change on any cycle and only matter at accept.
- in_data is ignored when not accepted.
- y*_ready asserted while y*_valid = 0 has no effect.

Decomposition:
- Shared package demux_pkg: localparams CH0 = 1'b0, CH1 = 1'b1, MODE_SEL = 1'b0, MODE_ALT = 1'b1, and default widths (BYTE_W = 8, CNT_W = 8).
- One sub-module is natural: demux_slot. It holds one output channel's data register, valid flag, load/drain logic and wrapping counter. demux_reg instantiates it twice and adds target select, in_ready and the rr pointer.

Test Plan:
- Reset mid-operation: load 0xA5 to ch0, assert reset asynchronously between edges -> y0_valid = 0, y0 = 0, cnt0 = 0 without waiting for a clock edge; in_ready = 1.
- Explicit routing: mode=0, send 0x11 sel=0 then 0x22 sel=1, ready low -> y0 = 0x11, y1 = 0x22, both valid; cnt0 = cnt1 = 1. Third byte to ch0 -> in_ready = 0, y0 stays 0x11.
- Alternation: mode=1, both readies high, stream 0x01..0x06 back-to-back -> ch0 sees 0x01, 0x03, 0x05 and ch1 sees 0x02, 0x04, 0x06, one byte per cycle, no stalls.
- Backpressure with rr hold: mode=1, y1_ready = 0 with y1 full, next byte targets ch1 -> in_ready = 0 and rr stays 1. Release y1_ready -> byte lands in ch1, then rr = 0.
- Simultaneous drain+load: ch0 holds 0x33, y0_ready = 1 and new byte 0x44 to ch0 in the same cycle -> y0 = 0x44, y0_valid stays 1, cnt0 increments once.
- Counter wrap: 256 accepted bytes into ch0 -> cnt0 returns to 0x00, cnt1 unchanged.
